uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable framing and a
// first-word-fall-through receive FIFO.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx_raw,
    output logic [DATA_BITS-1:0]               data_out,
    output logic                               data_valid,
    input  logic                               data_ready,
    output logic                               frame_error,
    output logic                               parity_error,
    output logic                               overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic [2:0]                         state
);

    localparam int DIV = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [DW-1:0] DIV_M1    = DW'(DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [2:0]           r_rst_sync;
    logic [DW-1:0]        r_div_cnt;
    logic [3:0]           r_tick_idx;
    logic [1:0]           r_samp;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_stop_err;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_ov;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [CW-1:0]        r_count;

    logic w_fall;
    logic w_tick;
    logic w_vote_tick;
    logic w_end_tick;
    logic w_vote;
    logic w_par_exp;
    logic w_last_stop;
    logic w_bad_stop;
    logic w_cnt_clr;
    logic w_shift;
    logic w_bit_inc;
    logic w_bit_clr;
    logic w_par_chk;
    logic w_stop_chk;
    logic w_frame_end;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Edges seen while reset release is still settling are ignored.
    assign w_fall      = r_prev & ~r_sync2 & ~r_rst_sync[2];
    assign w_tick      = (r_div_cnt == DIV_M1);
    assign w_vote_tick = w_tick & (r_tick_idx == 4'd8);
    assign w_end_tick  = w_tick & (r_tick_idx == 4'd15);
    assign w_vote      = (r_samp[1] & r_samp[0]) |
                         (r_samp[1] & r_sync2)   |
                         (r_samp[0] & r_sync2);
    assign w_par_exp   = (^r_shift) ^ (PARITY == 2);
    assign w_last_stop = (r_bit_cnt == LAST_STOP);
    assign w_bad_stop  = r_stop_err | ~w_vote;

    assign w_push_req  = w_frame_end & ~w_bad_stop & ~r_par_err;
    assign w_full      = (r_count == FULL);
    assign w_pop       = (r_count != '0) & data_ready;
    assign w_push      = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_par_chk   = 1'b0;
        w_stop_chk  = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next    = S_START;
                    w_cnt_clr = 1'b1;
                end
            end
            S_START: begin
                if (w_vote_tick && w_vote) begin
                    w_next = S_IDLE;
                end else if (w_end_tick) begin
                    w_next    = S_DATA;
                    w_bit_clr = 1'b1;
                end
            end
            S_DATA: begin
                w_shift = w_vote_tick;
                if (w_end_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_clr = 1'b1;
                        w_next    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_par_chk = w_vote_tick;
                if (w_end_tick) begin
                    w_next    = S_STOP;
                    w_bit_clr = 1'b1;
                end
            end
            S_STOP: begin
                // The frame closes at the last stop vote, not at bit end.
                if (w_vote_tick) begin
                    if (w_last_stop) begin
                        w_frame_end = 1'b1;
                        w_next      = w_vote ? S_IDLE : S_WAIT;
                    end else begin
                        w_stop_chk = 1'b1;
                    end
                end else if (w_end_tick) begin
                    w_bit_inc = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_sync2) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_rst_sync <= 3'b111;
            r_div_cnt  <= '0;
            r_tick_idx <= '0;
            r_samp     <= 2'b11;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_ov       <= 1'b0;
        end else begin
            r_sync1    <= rx_raw;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_rst_sync <= {r_rst_sync[1:0], 1'b0};

            if (w_cnt_clr) begin
                r_div_cnt  <= '0;
                r_tick_idx <= '0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_tick_idx <= r_tick_idx + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end

            if (w_tick && (r_tick_idx == 4'd6 || r_tick_idx == 4'd7)) begin
                r_samp <= {r_samp[0], r_sync2};
            end

            if (w_cnt_clr) begin
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_par_err  <= 1'b0;
                r_stop_err <= 1'b0;
            end else begin
                if (w_bit_clr) begin
                    r_bit_cnt <= '0;
                end else if (w_bit_inc) begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (w_shift) begin
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                end
                if (w_par_chk) begin
                    r_par_err <= w_vote ^ w_par_exp;
                end
                if (w_stop_chk && !w_vote) begin
                    r_stop_err <= 1'b1;
                end
            end

            r_fe <= w_frame_end & w_bad_stop;
            r_pe <= w_frame_end & ~w_bad_stop & r_par_err;
            r_ov <= w_push_req & w_full & ~w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign data_valid   = (r_count != '0);
    assign data_out     = data_valid ? r_mem[r_rd] : '0;
    assign fifo_count   = r_count;
    assign frame_error  = r_fe;
    assign parity_error = r_pe;
    assign overrun      = r_ov;
    assign state        = r_state;

endmodule
